// File: rtl/ram_arbiter_2h.sv
// Two-host arbiter (instruction fetch + data load/store) in front of a single-port RAM.
// Grants are combinational; each response is routed back to the host granted on the previous cycle.
module ram_arbiter_2h #(
  parameter int unsigned ArbMode     = 0,
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic       HostInstr = 1'b0;
  localparam logic       HostData  = 1'b1;
  localparam logic [7:0] StarveMax = 8'(StarveLimit);

  logic       last_q;
  logic [7:0] starve_cnt_q;
  logic [7:0] starve_cnt_d;
  owner_e     owner_q;
  owner_e     owner_d;
  logic       instr_wins;
  logic       gnt_instr;
  logic       gnt_data;

  // Conflict resolution only matters when both hosts request in the same cycle.
  always_comb begin
    if (ArbMode == 0) begin
      instr_wins = (last_q == HostData);
    end else begin
      instr_wins = (starve_cnt_q == StarveMax);
    end
  end

  assign gnt_instr = ~rst_i & instr_req_i & (~data_req_i | instr_wins);
  assign gnt_data  = ~rst_i & data_req_i & ~gnt_instr;

  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;
  assign ram_req_o   = gnt_instr | gnt_data;

  always_comb begin
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = 32'h0;
    ram_wdata_o = 32'h0;
    if (gnt_data) begin
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_addr_o  = data_addr_i;
      ram_wdata_o = data_wdata_i;
    end else if (gnt_instr) begin
      ram_be_o    = 4'hF;
      ram_addr_o  = instr_addr_i;
    end
  end

  // Count consecutive denied instr cycles; any break in the request clears it.
  always_comb begin
    starve_cnt_d = 8'd0;
    if ((ArbMode != 0) && instr_req_i && !gnt_instr) begin
      starve_cnt_d = (starve_cnt_q == StarveMax) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_instr) begin
      owner_d = OWN_INSTR;
    end else if (gnt_data) begin
      owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q       <= HostInstr;
      starve_cnt_q <= 8'd0;
      owner_q      <= OWN_NONE;
    end else begin
      if (gnt_instr || gnt_data) begin
        last_q <= gnt_data ? HostData : HostInstr;
      end
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
    end
  end

  // A response with no recorded owner (e.g. its grant was cut off by reset) is dropped.
  assign instr_rvalid_o = ~rst_i & ram_rvalid_i & (owner_q == OWN_INSTR);
  assign data_rvalid_o  = ~rst_i & ram_rvalid_i & (owner_q == OWN_DATA);
  assign instr_rdata_o  = (owner_q == OWN_INSTR) ? ram_rdata_i : 32'h0;
  assign data_rdata_o   = (owner_q == OWN_DATA)  ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_arbiter_2h.sv
// Bench for ram_arbiter_2h: instance 0 round-robin, instance 1 fixed priority with StarveLimit=3.
// Grants and RAM fields are checked in-cycle; responses go through an expected-response queue.
module tb_ram_arbiter_2h;

  localparam logic [1:0] G_N = 2'd0;
  localparam logic [1:0] G_I = 2'd1;
  localparam logic [1:0] G_D = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        instr_req[2];
  logic [31:0] instr_addr[2];
  logic        instr_gnt[2];
  logic        instr_rvalid[2];
  logic [31:0] instr_rdata[2];
  logic        data_req[2];
  logic        data_we[2];
  logic [3:0]  data_be[2];
  logic [31:0] data_addr[2];
  logic [31:0] data_wdata[2];
  logic        data_gnt[2];
  logic        data_rvalid[2];
  logic [31:0] data_rdata[2];
  logic        ram_req[2];
  logic        ram_we[2];
  logic [3:0]  ram_be[2];
  logic [31:0] ram_addr[2];
  logic [31:0] ram_wdata[2];
  logic        ram_rvalid[2];
  logic [31:0] ram_rdata[2];

  logic        model_rv[2];
  logic [31:0] model_rd[2];
  logic        force_rv[2];
  logic [31:0] mem[2][64] = '{default: '0};

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          k;
    logic        host;   // 0 = instr, 1 = data
    bit          chk;
    logic [31:0] data;
  } exp_t;
  exp_t expq[$];

  ram_arbiter_2h #(.ArbMode(0), .StarveLimit(4)) u0 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req[0]), .instr_addr_i(instr_addr[0]),
    .instr_gnt_o(instr_gnt[0]), .instr_rvalid_o(instr_rvalid[0]), .instr_rdata_o(instr_rdata[0]),
    .data_req_i(data_req[0]), .data_we_i(data_we[0]), .data_be_i(data_be[0]),
    .data_addr_i(data_addr[0]), .data_wdata_i(data_wdata[0]),
    .data_gnt_o(data_gnt[0]), .data_rvalid_o(data_rvalid[0]), .data_rdata_o(data_rdata[0]),
    .ram_req_o(ram_req[0]), .ram_we_o(ram_we[0]), .ram_be_o(ram_be[0]),
    .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]),
    .ram_rvalid_i(ram_rvalid[0]), .ram_rdata_i(ram_rdata[0])
  );

  ram_arbiter_2h #(.ArbMode(1), .StarveLimit(3)) u1 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req[1]), .instr_addr_i(instr_addr[1]),
    .instr_gnt_o(instr_gnt[1]), .instr_rvalid_o(instr_rvalid[1]), .instr_rdata_o(instr_rdata[1]),
    .data_req_i(data_req[1]), .data_we_i(data_we[1]), .data_be_i(data_be[1]),
    .data_addr_i(data_addr[1]), .data_wdata_i(data_wdata[1]),
    .data_gnt_o(data_gnt[1]), .data_rvalid_o(data_rvalid[1]), .data_rdata_o(data_rdata[1]),
    .ram_req_o(ram_req[1]), .ram_we_o(ram_we[1]), .ram_be_o(ram_be[1]),
    .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]),
    .ram_rvalid_i(ram_rvalid[1]), .ram_rdata_i(ram_rdata[1])
  );

  // Single-cycle RAM model per instance; responds to every accepted request.
  always @(posedge clk) begin
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      model_rv[k] <= ram_req[k];
      model_rd[k] <= mem[k][ram_addr[k][7:2]];
      if (ram_req[k] && ram_we[k]) begin
        w = mem[k][ram_addr[k][7:2]];
        for (int b = 0; b < 4; b++)
          if (ram_be[k][b]) w[8*b +: 8] = ram_wdata[k][8*b +: 8];
        mem[k][ram_addr[k][7:2]] <= w;
      end
    end
  end

  assign ram_rvalid[0] = model_rv[0] | force_rv[0];
  assign ram_rvalid[1] = model_rv[1] | force_rv[1];
  assign ram_rdata[0]  = model_rd[0];
  assign ram_rdata[1]  = model_rd[1];

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] own;
    logic [31:0] other;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      if (instr_rvalid[k] || data_rvalid[k]) begin
        if (expq.size() == 0) begin
          check($sformatf("resp_unexpected%0d", k), 1'b0, {30'd0, instr_rvalid[k], data_rvalid[k]}, 32'd0);
        end else begin
          e     = expq.pop_front();
          own   = e.host ? data_rdata[k] : instr_rdata[k];
          other = e.host ? instr_rdata[k] : data_rdata[k];
          ok = (e.k == k) && (instr_rvalid[k] == !e.host) && (data_rvalid[k] == e.host)
               && (other == 32'h0) && (!e.chk || own == e.data);
          check($sformatf("resp%0d_%s", k, e.host ? "data" : "instr"), ok, own, e.data);
        end
      end
    end
  end

  task automatic cyc(input int k, input logic r,
                     input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [3:0] be,
                     input logic [31:0] da, input logic [31:0] wd,
                     input logic [1:0] eg, input bit resp, input logic [31:0] ed, input int ecnt);
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    exp_t        e;
    @(posedge clk); #1;
    rst           = r;
    instr_req[k]  = ir;
    instr_addr[k] = ia;
    data_req[k]   = dr;
    data_we[k]    = dw;
    data_be[k]    = be;
    data_addr[k]  = da;
    data_wdata[k] = wd;
    @(negedge clk);
    check($sformatf("gnt%0d", k), {instr_gnt[k], data_gnt[k]} == {eg == G_I, eg == G_D},
          {30'd0, instr_gnt[k], data_gnt[k]}, {30'd0, eg == G_I, eg == G_D});
    e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
    if (eg == G_D) begin
      e_we = dw; e_be = be; e_addr = da; e_wd = wd;
    end else if (eg == G_I) begin
      e_be = 4'hF; e_addr = ia;
    end
    check($sformatf("ram_fields%0d", k),
          (ram_req[k] == (eg != G_N)) && (ram_we[k] == e_we) && (ram_be[k] == e_be)
          && (ram_addr[k] == e_addr) && (ram_wdata[k] == e_wd),
          {ram_req[k], ram_we[k], ram_be[k], ram_addr[k][25:0]}, {eg != G_N, e_we, e_be, e_addr[25:0]});
    if (ecnt >= 0)
      check("starve_cnt", u1.starve_cnt_q == 8'(ecnt), {24'd0, u1.starve_cnt_q}, 32'(ecnt));
    if (resp && eg != G_N) begin
      e.k    = k;
      e.host = (eg == G_D);
      e.chk  = !(eg == G_D && dw);
      e.data = ed;
      expq.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      instr_req[k] = 0; instr_addr[k] = 0; data_req[k] = 0; data_we[k] = 0;
      data_be[k] = 0; data_addr[k] = 0; data_wdata[k] = 0; force_rv[k] = 0;
    end

    // ---------------- instance 0: round-robin ----------------
    cyc(0, 1, 1, 32'h0, 1, 0, 4'hF, 32'h0, 32'h0, G_N, 0, 0, -1);
    cyc(0, 0, 0, 32'h0, 1, 1, 4'b0011, 32'h10, 32'hAABBCCDD, G_D, 1, 0, -1);
    cyc(0, 0, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, G_I, 1, 32'h0000CCDD, -1);
    cyc(0, 0, 1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, G_I, 1, 32'h0, -1);
    cyc(0, 0, 0, 32'h0, 1, 1, 4'hF, 32'h20, 32'h12345678, G_D, 1, 0, -1);
    cyc(0, 0, 0, 32'h0, 1, 1, 4'b1100, 32'h24, 32'h9ABCDEF0, G_D, 1, 0, -1);
    // data read granted, then reset hits while its response is in flight
    cyc(0, 0, 0, 32'h0, 1, 0, 4'hF, 32'h20, 32'h0, G_D, 0, 0, -1);
    cyc(0, 1, 1, 32'h24, 1, 0, 4'hF, 32'h20, 32'h0, G_N, 0, 0, -1);
    check("reset_drop_rvalid", !data_rvalid[0] && !instr_rvalid[0],
          {30'd0, instr_rvalid[0], data_rvalid[0]}, 32'd0);
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 1, 32'h24, 1, 0, 4'hF, 32'h20, 32'h0,
          (i % 2 == 0) ? G_D : G_I, 1, (i % 2 == 0) ? 32'h12345678 : 32'h9ABC0000, -1);
    cyc(0, 0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, G_N, 0, 0, -1);
    @(posedge clk); #1;
    force_rv[0] = 1; force_rv[1] = 1;
    @(negedge clk);
    check("forced_rvalid0", !instr_rvalid[0] && !data_rvalid[0], {30'd0, instr_rvalid[0], data_rvalid[0]}, 32'd0);
    check("forced_rvalid1", !instr_rvalid[1] && !data_rvalid[1], {30'd0, instr_rvalid[1], data_rvalid[1]}, 32'd0);
    force_rv[0] = 0; force_rv[1] = 0;
    cyc(0, 0, 1, 32'h40, 1, 0, 4'hF, 32'h10, 32'h0, G_D, 1, 32'h0000CCDD, -1);
    cyc(0, 0, 1, 32'h40, 1, 0, 4'hF, 32'h10, 32'h0, G_I, 1, 32'h0, -1);
    cyc(0, 0, 0, 32'h0, 1, 0, 4'hF, 32'h24, 32'h0, G_D, 1, 32'h9ABC0000, -1);
    cyc(0, 0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, G_N, 0, 0, -1);

    // ---------------- instance 1: fixed priority, StarveLimit=3 ----------------
    cyc(1, 0, 0, 32'h0, 1, 1, 4'hF, 32'h0, 32'h11112222, G_D, 1, 0, 0);
    cyc(1, 0, 0, 32'h0, 1, 1, 4'hF, 32'h4, 32'h33334444, G_D, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      cyc(1, 0, 1, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0,
          (i % 4 == 3) ? G_I : G_D, 1, (i % 4 == 3) ? 32'h11112222 : 32'h33334444, i % 4);
    cyc(1, 0, 1, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0, G_D, 1, 32'h33334444, 0);
    cyc(1, 0, 1, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0, G_D, 1, 32'h33334444, 1);
    // instr withdraws; its denied count must not carry over
    cyc(1, 0, 0, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0, G_D, 1, 32'h33334444, 2);
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 1, 32'h0, 1, 0, 4'hF, 32'h4, 32'h0,
          (i == 3) ? G_I : G_D, 1, (i == 3) ? 32'h11112222 : 32'h33334444, i);
    cyc(1, 0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, G_N, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", expq.size() == 0, 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
